// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Brief    : Widths shared by the multiplier top, Wallace tree and final adder.
// Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int PRODUCT_W   = 32;
    localparam int ADD_SPLIT_W = 16;
    localparam int HI_W        = PRODUCT_W - ADD_SPLIT_W;

    typedef logic [PRODUCT_W-1:0] product_t;

endpackage
`default_nettype wire

// File: rtl/wallace_final_adder_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : wallace_final_adder_pipe_if
// Brief    : Input beat (sum/carry vectors) and output product handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface wallace_final_adder_pipe_if
    import mult_pkg::*;
#(
    parameter int WIDTH = PRODUCT_W
) ();

    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] sum_vec;
    logic [WIDTH-1:0] carry_vec;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] product;

    // slave: the adder pipeline itself
    modport slave (
        input  s_valid, sum_vec, carry_vec, m_ready,
        output s_ready, m_valid, product
    );

    // master: whoever feeds the beats and consumes the product
    modport master (
        output s_valid, sum_vec, carry_vec, m_ready,
        input  s_ready, m_valid, product
    );

endinterface
`default_nettype wire

// File: rtl/cpa_slice.sv
`default_nettype none
// ============================================================================
// Module   : cpa_slice
// Brief    : N-bit carry-propagate adder with carry-in and carry-out.
// Revision : 1.0 - initial release
// ============================================================================
module cpa_slice #(
    parameter int N = 16
) (
    input  wire logic [N-1:0] a_i,
    input  wire logic [N-1:0] b_i,
    input  wire logic         cin_i,
    output      logic [N-1:0] sum_o,
    output      logic         cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};

endmodule
`default_nettype wire

// File: rtl/wallace_final_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : wallace_final_adder_pipe
// Brief    : Two-stage split-carry final adder; low slice in S1, high slice
//            plus the registered low carry in S2, valid/ready on both ends.
// Revision : 1.0 - initial release
// ============================================================================
module wallace_final_adder_pipe
    import mult_pkg::*;
#(
    parameter int WIDTH = PRODUCT_W,
    parameter int LO_W  = ADD_SPLIT_W
) (
    input wire logic                  sys_clk,
    input wire logic                  sys_rst_n,
    wallace_final_adder_pipe_if.slave bus
);

    localparam int HI_N = WIDTH - LO_W;

    logic [LO_W-1:0]  lo_q, lo_d;
    logic             c_lo_q, c_lo_d;
    logic [HI_N-1:0]  hi_sum_q, hi_sum_d;
    logic [HI_N-1:0]  hi_carry_q, hi_carry_d;
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic             m_valid_q, m_valid_d;

    logic [LO_W-1:0]  s1_lo_sum;
    logic             s1_lo_cout;
    logic [HI_N-1:0]  s2_hi_sum;
    logic             hi_cout_unused;

    logic s2_load;
    logic s1_load;
    logic s_ready;

    cpa_slice #(.N(LO_W)) u_cpa_lo (
        .a_i    (bus.sum_vec[LO_W-1:0]),
        .b_i    (bus.carry_vec[LO_W-1:0]),
        .cin_i  (1'b0),
        .sum_o  (s1_lo_sum),
        .cout_o (s1_lo_cout)
    );

    // The top carry-out is dropped: the product is taken modulo 2^WIDTH.
    cpa_slice #(.N(HI_N)) u_cpa_hi (
        .a_i    (hi_sum_q),
        .b_i    (hi_carry_q),
        .cin_i  (c_lo_q),
        .sum_o  (s2_hi_sum),
        .cout_o (hi_cout_unused)
    );

    assign s2_load = s1_valid_q && (!m_valid_q || bus.m_ready);
    assign s_ready = !s1_valid_q || s2_load;
    assign s1_load = bus.s_valid && s_ready;

    always_comb begin
        lo_d       = lo_q;
        c_lo_d     = c_lo_q;
        hi_sum_d   = hi_sum_q;
        hi_carry_d = hi_carry_q;
        s1_valid_d = s1_valid_q;
        product_d  = product_q;
        m_valid_d  = m_valid_q;

        if (s1_load) begin
            lo_d       = s1_lo_sum;
            c_lo_d     = s1_lo_cout;
            hi_sum_d   = bus.sum_vec[WIDTH-1:LO_W];
            hi_carry_d = bus.carry_vec[WIDTH-1:LO_W];
            s1_valid_d = 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            product_d = {s2_hi_sum, lo_q};
            m_valid_d = 1'b1;
        end else if (bus.m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lo_q       <= '0;
            c_lo_q     <= 1'b0;
            hi_sum_q   <= '0;
            hi_carry_q <= '0;
            s1_valid_q <= 1'b0;
            product_q  <= '0;
            m_valid_q  <= 1'b0;
        end else begin
            lo_q       <= lo_d;
            c_lo_q     <= c_lo_d;
            hi_sum_q   <= hi_sum_d;
            hi_carry_q <= hi_carry_d;
            s1_valid_q <= s1_valid_d;
            product_q  <= product_d;
            m_valid_q  <= m_valid_d;
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_wallace_final_adder_pipe.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module   : tb_wallace_final_adder_pipe
// Brief    : Randomised scoreboard bench for the final adder pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wallace_final_adder_pipe;

    logic sys_clk   = 1'b0;
    logic sys_rst_n;

    wallace_final_adder_pipe_if #(.WIDTH(32)) bus ();

    wallace_final_adder_pipe #(.WIDTH(32), .LO_W(16)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] exp;
        int unsigned k;
    } ent_t;

    ent_t        sb_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          rst_epoch = 0;

    int          mon_seen = 0;
    int unsigned mon_cyc  = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_prod  = '0;
    logic        exp_mv;
    logic        exp_sr;
    logic        acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: the model sees the pipe only as an ordered list of accepted
    // beats; the oldest is visible two cycles after its acceptance.
    initial begin
        forever begin
            @(negedge sys_clk);
            mon_cyc++;
            if (!sys_rst_n || mon_seen != rst_epoch) begin
                sb_q.delete();
                mon_seen   = rst_epoch;
                prev_stall = 1'b0;
            end
            if (sys_rst_n) begin
                exp_mv = (sb_q.size() > 0) && ((mon_cyc - sb_q[0].k) >= 2);
                exp_sr = (sb_q.size() < 2) || bus.m_ready;
                chk("m_valid", {31'b0, bus.m_valid}, {31'b0, exp_mv});
                chk("s_ready", {31'b0, bus.s_ready}, {31'b0, exp_sr});
                if (bus.m_valid && sb_q.size() > 0)
                    chk("product", bus.product, sb_q[0].exp);
                if (prev_stall)
                    chk("hold_product", bus.product, prev_prod);
                if (bus.m_valid && bus.m_ready && sb_q.size() > 0)
                    void'(sb_q.pop_front());
                if (bus.s_valid && bus.s_ready)
                    sb_q.push_back('{exp: bus.sum_vec + bus.carry_vec, k: mon_cyc});
                prev_stall = bus.m_valid && !bus.m_ready;
                prev_prod  = bus.product;
            end
        end
    end

    task automatic wait_accept();
        for (int t = 0; t < 50; t++) begin
            @(negedge sys_clk);
            if (bus.s_ready) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout: got no s_ready expected s_ready within 50 cycles");
    endtask

    task automatic send(input logic [31:0] s, input logic [31:0] c, input logic mr);
        @(posedge sys_clk);
        #1;
        bus.s_valid   = 1'b1;
        bus.sum_vec   = s;
        bus.carry_vec = c;
        bus.m_ready   = mr;
        wait_accept();
    endtask

    task automatic idle(input int n, input logic mr);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
            bus.s_valid = 1'b0;
            bus.m_ready = mr;
        end
    endtask

    // Single beat into an empty pipe; product must show exactly two cycles later.
    task automatic send_check(input string name, input logic [31:0] s,
                              input logic [31:0] c, input logic [31:0] exp);
        send(s, c, 1'b1);
        @(posedge sys_clk);
        #1;
        bus.s_valid = 1'b0;
        @(negedge sys_clk);
        chk({name, "_early"}, {31'b0, bus.m_valid}, 32'd0);
        @(negedge sys_clk);
        chk({name, "_valid"}, {31'b0, bus.m_valid}, 32'd1);
        chk(name, bus.product, exp);
    endtask

    initial begin
        bus.s_valid   = 1'b0;
        bus.sum_vec   = '0;
        bus.carry_vec = '0;
        bus.m_ready   = 1'b0;
        sys_rst_n     = 1'b1;
        #2;
        sys_rst_n = 1'b0;
        rst_epoch++;
        #1;
        chk("rst_m_valid", {31'b0, bus.m_valid}, 32'd0);
        chk("rst_product", bus.product, 32'd0);
        chk("rst_s_ready", {31'b0, bus.s_ready}, 32'd1);
        repeat (3) @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b1;

        send_check("split_carry", 32'h0000FFFF, 32'h00000001, 32'h00010000);
        idle(3, 1'b1);
        send_check("wrap_ones", 32'hFFFFFFFF, 32'h00000001, 32'h00000000);
        idle(3, 1'b1);
        send_check("wrap_msb", 32'h80000000, 32'h80000000, 32'h00000000);
        idle(3, 1'b1);

        for (int i = 0; i < 100; i++)
            send($urandom, $urandom, 1'b1);
        idle(4, 1'b1);

        // Backpressure: A and B fill the pipe, C must be refused until m_ready.
        send(32'h00001234, 32'h00000001, 1'b0);
        send(32'h000000FF, 32'h00000001, 1'b0);
        @(posedge sys_clk);
        #1;
        bus.sum_vec   = 32'hCAFE0000;
        bus.carry_vec = 32'h0000BEEF;
        repeat (2) begin
            @(negedge sys_clk);
            chk("bp_s_ready_low", {31'b0, bus.s_ready}, 32'd0);
            chk("bp_product_a", bus.product, 32'h00001235);
        end
        @(posedge sys_clk);
        #1;
        bus.m_ready = 1'b1;
        #1;
        chk("bp_s_ready_same_cycle", {31'b0, bus.s_ready}, 32'd1);
        wait_accept();
        idle(6, 1'b1);

        // Asynchronous reset with two beats in flight.
        send(32'h11111111, 32'h22222222, 1'b0);
        send(32'h33333333, 32'h44444444, 1'b0);
        @(posedge sys_clk);
        #1;
        bus.s_valid = 1'b0;
        #1;
        sys_rst_n = 1'b0;
        rst_epoch++;
        #0.5;
        chk("midrst_m_valid", {31'b0, bus.m_valid}, 32'd0);
        chk("midrst_product", bus.product, 32'd0);
        chk("midrst_s_ready", {31'b0, bus.s_ready}, 32'd1);
        #1;
        sys_rst_n = 1'b1;
        idle(6, 1'b1);

        for (int i = 0; i < 10000; i++) begin
            @(negedge sys_clk);
            acc = bus.s_valid && bus.s_ready;
            @(posedge sys_clk);
            #1;
            if (!bus.s_valid || acc) begin
                bus.s_valid   = ($urandom % 4) != 0;
                bus.sum_vec   = $urandom;
                bus.carry_vec = ($urandom % 8 == 0) ? (~bus.sum_vec + 32'd1) : $urandom;
            end
            bus.m_ready = ($urandom % 3) != 0;
        end
        idle(8, 1'b1);
        @(negedge sys_clk);
        chk("drain_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/wallace_final_adder_pipe.md
# wallace_final_adder_pipe

Final carry-propagate stage of the Booth-4 / Wallace-tree 16×16 multiplier. It sits directly downstream of the last 3:2 compressor row and receives that row's redundant sum and carry vectors. It adds the two vectors in a two-stage, split-carry pipeline and presents the 32-bit product on a valid/ready handshake. Throughput is one product per cycle, with full backpressure support.

## Interface
- WIDTH, 32, product width and the width of both the sum and carry vectors
- LO_W, 16, width of the low slice added in stage 1; the high slice is WIDTH-LO_W bits
- sys_clk  in  1  single clock; all registers update on its rising edge
- sys_rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  sum_vec/carry_vec hold a valid beat
- s_ready  out  1  stage accepts a beat this cycle
- sum_vec  in  WIDTH  sum vector from the final compressor row
- carry_vec  in  WIDTH  carry vector from the final compressor row, already left-aligned by the upstream stage (no shift applied here)
- m_valid  out  1  product holds a valid result
- m_ready  in  1  consumer takes the product this cycle
- product  out  WIDTH  (sum_vec + carry_vec) mod 2^WIDTH

## Operation
- Result: product = (sum_vec + carry_vec) mod 2^WIDTH. Carry-out of bit WIDTH-1 is discarded; it is meaningless for a two's-complement product.
- Stage 1 (S1): registers {c_lo, lo} = sum_vec[LO_W-1:0] + carry_vec[LO_W-1:0].
  - Also registers sum_vec[WIDTH-1:LO_W] and carry_vec[WIDTH-1:LO_W] unchanged.
  - Sets s1_valid.
- Stage 2 (S2): registers product = {hi_sum + hi_carry + c_lo, lo}. Sets m_valid (m_valid is the S2 valid flag).
- Advance rules:
  - S2 loads when s1_valid and (!m_valid or m_ready).
  - S1 loads when s_valid and s_ready.
- s_ready = !s1_valid or S2 loads this cycle. This is a combinational path from m_ready to s_ready and is permitted.
- Transfers occur only on valid&ready.
- While a stage holds a beat and is not advancing, its data and valid flag are held unchanged.
- Simultaneous events:
  - Output taken and S1 beat moving into S2 in the same cycle: S2 is overwritten with the new beat and m_valid stays 1.
  - S1 emptying and a new input accepted in the same cycle: S1 reloads and s1_valid stays 1.
  - There are no bubbles under continuous s_valid and m_ready.
- Upstream protocol: once asserted, s_valid and the data must remain stable until accepted. The block does not check this.
- Flags on empty: s1_valid=0 or m_valid=0 marks the stage empty. Stale data in an empty stage is don't-care but must never reach the outputs with m_valid=1.

## Timing
- Reset (sys_rst_n low, asynchronous):
  - s1_valid=0, m_valid=0, product=0, and all data registers = 0.
  - s_ready therefore reads 1 during and after reset.
- Reset mid-operation: all in-flight beats are dropped. No output beat follows reset release until a new input is accepted.
- Latency: a beat accepted in cycle n presents m_valid=1 and its product in cycle n+2, provided m_ready was not stalling S2.
- Throughput: 1 beat/cycle. Capacity is 2 beats (S1 + S2).
- Under m_ready=0 with S1 and S2 both full, s_ready=0. The first m_ready=1 cycle reasserts s_ready in that same cycle.
- Critical path: one LO_W-bit adder in S1 and one (WIDTH-LO_W)-bit adder plus carry-in in S2. No full-width carry chain exists in any single cycle.

## Structure
- Shared package mult_pkg holds:
  - PRODUCT_W = 32 and ADD_SPLIT_W = 16, which the multiplier top, the Wallace tree and this block all use.
  - A localparam for HI_W = PRODUCT_W - ADD_SPLIT_W.
- One sub-module is natural: cpa_slice, a parameterised N-bit adder with carry-in and carry-out. It is instantiated twice:
  - S1 uses N=LO_W with cin=0.
  - S2 uses N=WIDTH-LO_W with cin=c_lo.
- Pipeline registers and handshake logic stay in wallace_final_adder_pipe.

## Test plan
- Carry across split: sum_vec=0x0000FFFF, carry_vec=0x00000001, m_ready=1 → product=0x00010000 with m_valid=1 exactly 2 cycles after acceptance.
- Wrap: sum_vec=0xFFFFFFFF, carry_vec=0x00000001 → product=0x00000000; also 0x80000000+0x80000000 → 0x00000000.
- Streaming: 100 back-to-back random beats with s_valid=1 and m_ready=1 → one product per cycle, in order, each equal to (sum+carry) mod 2^32, with no bubbles.
- Backpressure: m_ready=0 while presenting beats A=0x1234+0x0001, B=0x00FF+0x0001, C → A and B accepted, s_ready=0 while C is held. Raise m_ready → outputs 0x00001235, 0x00000100, then C, in order with no loss or duplication.
- Reset mid-flight: two beats in the pipe, pulse sys_rst_n low asynchronously between clock edges → m_valid=0, product=0 and s_ready=1 immediately. No stale beat appears after release.
- Random valid/ready toggling for 10k cycles → scoreboard matches exactly, and the output holds stable while m_valid=1 and m_ready=0.
